// File: rtl/shift_unit_if.sv
// Handshake/data bundle between the control unit (master) and the shift unit (slave).
interface shift_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  n;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    modport master (
        output start, op, n, data_in,
        input  data_out, busy, done
    );

    modport slave (
        input  start, op, n, data_in,
        output data_out, busy, done
    );
endinterface

// File: rtl/shift_unit.sv
// Multicycle 32-bit shifter (SLL/SRL/SRA, op 11 passes through), one bit per cycle.
// Define SHIFT_UNIT_FAST_EN to compute the whole shift in the start cycle instead.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; data_out holds last result
// S_SHIFT | shifting data_out one position per cycle, cnt counts down
// S_DONE  | done pulse; data_out is the final result; start accepted
module shift_unit (
    input logic         clk,
    input logic         reset,
    shift_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q,  data_d;
    logic [1:0]  op_q,    op_d;
    logic [4:0]  cnt_q,   cnt_d;

    function automatic logic [31:0] shift_one(input logic [31:0] d, input logic [1:0] o);
        case (o)
            2'b00:   shift_one = {d[30:0], 1'b0};
            2'b01:   shift_one = {1'b0, d[31:1]};
            2'b10:   shift_one = {d[31], d[31:1]};
            default: shift_one = d;
        endcase
    endfunction

`ifdef SHIFT_UNIT_FAST_EN
    function automatic logic [31:0] shift_full(input logic [31:0] d, input logic [1:0] o,
                                                input logic [4:0] amt);
        case (o)
            2'b00:   shift_full = d << amt;
            2'b01:   shift_full = d >> amt;
            2'b10:   shift_full = 32'($signed(d) >>> amt);
            default: shift_full = d;
        endcase
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    op_d  = bus.op;
                    cnt_d = bus.n;
`ifdef SHIFT_UNIT_FAST_EN
                    data_d  = shift_full(bus.data_in, bus.op, bus.n);
                    state_d = S_DONE;
`else
                    data_d  = bus.data_in;
                    state_d = (bus.n == 5'd0 || bus.op == 2'b11) ? S_DONE : S_SHIFT;
`endif
                end
            end
            S_SHIFT: begin
                data_d = shift_one(data_q, op_q);
                cnt_d  = cnt_q - 5'd1;
                // cnt==1 means this edge performs the final shift
                if (cnt_q == 5'd1) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.busy     = (state_q == S_SHIFT);
    assign bus.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed vector table, corner sequences, random ops.
module tb_shift_unit;

`ifdef SHIFT_UNIT_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    shift_unit_if bus ();

    shift_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  n;
        logic [31:0] din;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: shift by plain arithmetic; SRA via sign-extension to 64 bits.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] o,
                                              input logic [4:0] amt);
        logic [63:0] ext;
        ext = {{32{d[31]}}, d};
        case (o)
            2'b00:   return d << amt;
            2'b01:   return d >> amt;
            2'b10:   return ext[31:0] >> 0 == 0 ? 32'(ext >> amt) : 32'(ext >> amt);
            default: return d;
        endcase
    endfunction

    // Edges after the accepting edge until done is visible.
    function automatic int ref_lat(input logic [1:0] o, input logic [4:0] amt);
        if (FAST || amt == 5'd0 || o == 2'b11) return 0;
        return int'(amt);
    endfunction

    // Drives start in the current cycle; returns in the done cycle (or after timeout).
    task automatic do_op(input logic [1:0] o, input logic [4:0] amt, input logic [31:0] din,
                         input logic [31:0] exp, input string name);
        int lat;
        int seen;
        bit busy_bad;
        lat      = ref_lat(o, amt);
        seen     = -1;
        busy_bad = 1'b0;
        bus.op      = o;
        bus.n       = amt;
        bus.data_in = din;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.op      = 2'($urandom);
        bus.n       = 5'($urandom);
        bus.data_in = $urandom;
        for (int k = 0; k <= 40; k++) begin
            if (bus.busy !== (k < lat)) busy_bad = 1'b1;
            if (bus.done === 1'b1) begin
                seen = k;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, " latency"}, 32'(seen), 32'(lat));
        check({name, " busy"}, {31'd0, busy_bad}, 32'd0);
        check({name, " data"}, bus.data_out, exp);
    endtask

    initial begin
        int dones;
        logic [31:0] got;
        logic [1:0]  ro;
        logic [4:0]  rn;
        logic [31:0] rd;

        checks = 0;
        errors = 0;

        vecs[0] = '{2'b00, 5'd16, 32'h0000_1234, 32'h1234_0000, "sll_lui"};
        vecs[1] = '{2'b10, 5'd4,  32'h8000_0000, 32'hF800_0000, "sra_sign"};
        vecs[2] = '{2'b01, 5'd4,  32'h8000_0000, 32'h0800_0000, "srl_4"};
        vecs[3] = '{2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, "srl_zero"};
        vecs[4] = '{2'b11, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, "reserved"};
        vecs[5] = '{2'b10, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000, "sra_pos31"};
        vecs[6] = '{2'b10, 5'd31, 32'h8000_0001, 32'hFFFF_FFFF, "sra_neg31"};
        vecs[7] = '{2'b00, 5'd31, 32'h0000_0003, 32'h8000_0000, "sll_31"};
        vecs[8] = '{2'b00, 5'd1,  32'hC000_0001, 32'h8000_0002, "sll_1"};
        vecs[9] = '{2'b10, 5'd1,  32'hC000_0001, 32'hE000_0000, "sra_1"};

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.n       = 5'd0;
        bus.data_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", bus.data_out, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table, each followed by one idle cycle to confirm hold and single pulse.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].n, vecs[i].din, vecs[i].exp, vecs[i].name);
            @(posedge clk); #1;
            check({vecs[i].name, " done_pulse"}, {31'd0, bus.done}, 32'd0);
            check({vecs[i].name, " hold"}, bus.data_out, vecs[i].exp);
        end

        // Back-to-back: max-length shift, then a new start in its done cycle.
        do_op(2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, "b2b_srl31");
        do_op(2'b00, 5'd1, 32'h0000_0001, 32'h0000_0002, "b2b_sll1");
        @(posedge clk); #1;

`ifndef SHIFT_UNIT_FAST_EN
        // start pulsed mid-shift must be ignored.
        bus.op = 2'b00; bus.n = 5'd8; bus.data_in = 32'd1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.n = 5'd1; bus.data_in = 32'd5;
        @(posedge clk); #1; bus.start = 1'b0;
        dones = 0;
        got   = 32'hX;
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1) begin
                dones++;
                if (dones == 1) got = bus.data_out;
            end
            @(posedge clk); #1;
        end
        check("ignore_busy dones", 32'(dones), 32'd1);
        check("ignore_busy data", got, 32'h0000_0100);
`endif

        // Reset in the middle of a long shift.
        bus.op = 2'b00; bus.n = 5'd20; bus.data_in = 32'hFFFF_FFFF; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset data_out", bus.data_out, 32'd0);
        check("midreset busy", {31'd0, bus.busy}, 32'd0);
        check("midreset done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        check("midreset later_done", 32'(dones), 32'd0);

        // Reset and start at the same edge: reset wins.
        bus.op = 2'b00; bus.n = 5'd3; bus.data_in = 32'd7; bus.start = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        reset = 1'b0;
        check("rst_start busy", {31'd0, bus.busy}, 32'd0);
        check("rst_start data_out", bus.data_out, 32'd0);
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        check("rst_start dones", 32'(dones), 32'd0);

        // Random operations against the reference, with random idle gaps or back-to-back.
        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom);
            rn = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
            rd = $urandom;
            do_op(ro, rn, rd, ref_shift(rd, ro, rn), "rand");
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
